gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 2-input combinational gate. It drives the gate's a/b inputs through all four combinations, waits a programmable settle time per combination, and captures the gate output into a 4-bit truth table. On completion it compares the table against an expected pattern and reports pass/fail plus the first mismatching index. It sits between a lab control/LED panel and the gate under test.

Parameters:
SETTLE_CYCLES, 4, clock cycles each input combination is held before o_y is sampled; legal range >= 1; 0 is illegal.
CNT_W, 3, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES-1.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous reset, active low.
i_start  input  1  start request; level sampled each edge, accepted only in IDLE.
i_abort  input  1  abort request; highest priority after reset.
i_expected  input  4  expected truth table; bit k = expected y for index k = {b,a}.
i_y  input  1  gate output under test.
o_a  output  1  gate input a (= idx[0]).
o_b  output  1  gate input b (= idx[1]).
o_busy  output  1  high while a sweep is in progress.
o_done  output  1  one-cycle pulse at sweep completion.
o_table  output  4  captured truth table; bit k = sampled y for index k.
o_pass  output  1  1 if o_table == latched expected; valid from o_done, held until next accepted start.
o_err_idx  output  2  lowest index k with mismatch; 0 when o_pass=1.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_a, o_b, o_busy, o_done, o_pass = 0; o_table = 0; o_err_idx = 0; idx = 0; cnt = 0; latched expected = 0.
- States: IDLE, SETTLE, DONE. All outputs are registered.
- IDLE: on an edge with i_start=1 and i_abort=0: latch i_expected, clear o_table, o_pass, o_err_idx; idx<=0; cnt<=0; o_a/o_b<=0; o_busy<=1; go SETTLE.
- SETTLE: o_a/o_b = idx bits; cnt increments each edge. On the edge where cnt==SETTLE_CYCLES-1: o_table[idx]<=i_y; cnt<=0. If idx<3: idx<=idx+1 and o_a/o_b update on the same edge. If idx==3: go DONE.
- Each index is therefore held for exactly SETTLE_CYCLES cycles.
- Latency: with the start accepted at edge E0, idx k is sampled at edge E0+(k+1)*SETTLE_CYCLES. DONE is entered at E0+4*SETTLE_CYCLES.
- On DONE entry, the following are all registered on the same edge:
  - o_busy<=0, o_done<=1, o_a/o_b<=0.
  - o_pass <= (final table == latched expected). The final table includes the bit sampled on that edge.
  - o_err_idx <= lowest mismatching index, or 0 if there is no mismatch.
- DONE: lasts one cycle, then IDLE with o_done<=0. i_start is ignored in DONE; a start held high is re-accepted on the first IDLE edge.
- i_start while busy: ignored; no restart.
- i_abort=1 at any edge in SETTLE or DONE: next state IDLE; o_busy, o_done, o_a, o_b <= 0. o_table keeps its partial contents; o_pass<=0; o_err_idx unchanged; no o_done pulse.
- i_abort and i_start both 1 in IDLE: abort wins; remain IDLE.
- Reset mid-sweep: immediate asynchronous return to reset values, with no pulse on o_done.
- i_expected changes during a sweep have no effect; only the value latched at start is used.
- i_y is sampled synchronously; no synchronizer is inside this block.

Test Plan:
- SETTLE_CYCLES=4, bench models an AND gate, i_expected=4'b1000, single start pulse:
  - a/b sequence (b,a) = 00, 01, 10, 11, each held 4 cycles.
  - o_done pulses exactly 16 cycles after the accept edge.
  - o_table=4'b1000, o_pass=1, o_err_idx=0.
- Same setup but gate modelled as OR (table 1110), i_expected=4'b1000 -> o_table=4'b1110, o_pass=0, o_err_idx=1.
- i_start pulsed again at idx=2 mid-sweep -> ignored. Timing is unchanged and a single o_done pulse occurs at cycle 16.
- i_abort asserted in idx=2 (cycle 9) with AND gate:
  - Next cycle: o_busy=0, o_a=o_b=0, o_table=4'b0000, o_pass=0.
  - No o_done pulse.
- i_rst_n driven low mid-SETTLE at idx=1 -> all outputs 0 immediately, without waiting for a clock edge.
  - After release, a new start completes a normal sweep.
- SETTLE_CYCLES=1, XOR gate, i_expected=4'b0110, i_start held high for 12 cycles:
  - o_done pulses 4 cycles after the first accept, with o_pass=1.
  - The second sweep is accepted on the first IDLE edge after DONE.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives a 2-input gate through {b,a} = 00,01,10,11, holds each
// combination for SETTLE_CYCLES clocks, samples i_y into a 4-bit truth table and
// compares it with the expected table latched when the sweep was accepted.
// Handshake: i_start is a level request taken only on an IDLE edge without
// i_abort; o_done is a one-cycle completion strobe and o_table/o_pass/o_err_idx
// are valid from that strobe until the next accepted start.
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [3:0] i_expected,
  input  logic       i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_table,
  output logic       o_pass,
  output logic [1:0] o_err_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       exp_q, exp_d;
  logic [3:0]       table_q, table_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       err_q, err_d;

  logic             settle_last;
  logic [1:0]       idx_inc;
  logic [3:0]       table_smp;
  logic [3:0]       mismatch;
  logic [1:0]       err_first;
  logic             accept;

  assign settle_last = (cnt_q == CNT_LAST);
  assign idx_inc     = idx_q + 2'd1;
  assign accept      = i_start && !i_abort;

  // Table as it will look once the current index is sampled, plus its lowest mismatch
  always_comb begin
    table_smp        = table_q;
    table_smp[idx_q] = i_y;
    mismatch         = table_smp ^ exp_q;
    err_first        = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mismatch[k]) err_first = 2'(k);
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort dominates every other request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETTLE;
      SETTLE: begin
        if (i_abort)                          state_d = IDLE;
        else if (settle_last && idx_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; every output is a flop
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          exp_d   = i_expected;
          table_d = 4'd0;
          pass_d  = 1'b0;
          err_d   = 2'd0;
          idx_d   = 2'd0;
          cnt_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        if (i_abort) begin
          busy_d = 1'b0;
          a_d    = 1'b0;
          b_d    = 1'b0;
          pass_d = 1'b0;
        end else if (settle_last) begin
          table_d = table_smp;
          cnt_d   = '0;
          if (idx_q != 2'd3) begin
            idx_d = idx_inc;
            a_d   = idx_inc[0];
            b_d   = idx_inc[1];
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
            a_d    = 1'b0;
            b_d    = 1'b0;
            pass_d = (table_smp == exp_q);
            err_d  = err_first;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (i_abort) pass_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      exp_q   <= 4'd0;
      table_q <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 2'd0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign o_a       = a_q;
  assign o_b       = b_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_table   = table_q;
  assign o_pass    = pass_q;
  assign o_err_idx = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE_CYCLES=4 and 1) each driving a
// gate modelled as a 4-entry lookup table. A reference model predicts busy,
// a/b and done every cycle; sweep results go through a scoreboard queue.
module tb_gate_sweep_ctrl;

  localparam int W = 27;  // {done_edge[19:0], err[1:0], pass, table[3:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       start [2];
  logic       abort [2];
  logic [3:0] expd  [2];
  logic [3:0] lut   [2];
  logic       a     [2];
  logic       b     [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic       y     [2];
  logic [3:0] tbl   [2];
  logic [1:0] erri  [2];

  assign y[0] = lut[0][{b[0], a[0]}];
  assign y[1] = lut[1][{b[1], a[1]}];

  gate_sweep_ctrl #(.SETTLE_CYCLES(4), .CNT_W(3)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
    .i_expected(expd[0]), .i_y(y[0]), .o_a(a[0]), .o_b(b[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_table(tbl[0]), .o_pass(pass[0]), .o_err_idx(erri[0])
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
    .i_expected(expd[1]), .i_y(y[1]), .o_a(a[1]), .o_b(b[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_table(tbl[1]), .o_pass(pass[1]), .o_err_idx(erri[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int settle(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Result of sweeping gate lut[i] against expd[i], accepted at edge n
  function automatic logic [W-1:0] predict(input int i, input int n);
    logic [3:0] t;
    logic [3:0] e;
    logic [1:0] err;
    logic       ok;
    t   = lut[i];
    e   = expd[i];
    ok  = (t == e);
    err = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (t[k] != e[k]) err = 2'(k);
    end
    return {20'(n + 4 * settle(i)), err, ok, t};
  endfunction

  // ---------------- reference model (sweep-level) ----------------
  bit m_act   [2];
  int m_e0    [2];
  int m_dedge [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i]   = 1'b0;
      m_e0[i]    = 0;
      m_dedge[i] = -100;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_act[i]   = 1'b0;
          m_dedge[i] = -100;
          if (i == 0) exp_q0.delete(); else exp_q1.delete();
        end else if (m_act[i]) begin
          if (abort[i]) begin
            m_act[i] = 1'b0;
            if (i == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
          end else if (cyc == m_e0[i] + 4 * settle(i)) begin
            m_act[i]   = 1'b0;
            m_dedge[i] = cyc;
          end
        end else if (cyc != m_dedge[i] + 1 && start[i] && !abort[i]) begin
          m_act[i] = 1'b1;
          m_e0[i]  = cyc;
          if (i == 0) exp_q0.push_back(predict(0, cyc));
          else        exp_q1.push_back(predict(1, cyc));
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          int           ab_exp;
          logic [W-1:0] v;
          int           qs;
          ab_exp = m_act[i] ? ((cyc - m_e0[i]) / settle(i)) : 0;
          check($sformatf("busy%0d", i), int'(busy[i]), int'(m_act[i]));
          check($sformatf("done%0d", i), int'(done[i]), int'(m_dedge[i] == cyc));
          check($sformatf("ba%0d", i), int'({b[i], a[i]}), ab_exp);
          if (done[i]) begin
            qs = (i == 0) ? exp_q0.size() : exp_q1.size();
            check($sformatf("sb_pending%0d", i), int'(qs > 0), 1);
            if (qs > 0) begin
              v = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("table%0d", i), int'(tbl[i]), int'(v[3:0]));
              check($sformatf("pass%0d", i), int'(pass[i]), int'(v[4]));
              check($sformatf("err_idx%0d", i), int'(erri[i]), int'(v[6:5]));
              check($sformatf("done_cyc%0d", i), cyc, int'(v[26:7]));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sweep(input int i, input logic [3:0] l, input logic [3:0] e);
    lut[i]   = l;
    expd[i]  = e;
    start[i] = 1'b1;
    tick(1);
    start[i] = 1'b0;
  endtask

  task automatic check_zero(input int i);
    check($sformatf("rst_a%0d", i), int'(a[i]), 0);
    check($sformatf("rst_b%0d", i), int'(b[i]), 0);
    check($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
    check($sformatf("rst_done%0d", i), int'(done[i]), 0);
    check($sformatf("rst_table%0d", i), int'(tbl[i]), 0);
    check($sformatf("rst_pass%0d", i), int'(pass[i]), 0);
    check($sformatf("rst_err%0d", i), int'(erri[i]), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      expd[i]  = 4'd0;
      lut[i]   = 4'd0;
    end
    #3;
    check_zero(0);
    check_zero(1);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // AND gate, matching expectation
    sweep(0, 4'b1000, 4'b1000);
    tick(20);
    // OR gate against AND expectation: mismatch, lowest index 1
    sweep(0, 4'b1110, 4'b1000);
    tick(20);
    // Extra start pulse during idx 2 must be ignored
    sweep(0, 4'b1000, 4'b1000);
    tick(8);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(12);
    // Abort during idx 2 (ninth edge after accept)
    sweep(0, 4'b1000, 4'b1000);
    tick(8);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    check("abort_table", int'(tbl[0]), 0);
    check("abort_pass", int'(pass[0]), 0);
    check("abort_busy", int'(busy[0]), 0);
    check("abort_ba", int'({b[0], a[0]}), 0);
    tick(12);
    // Asynchronous reset during idx 1, then a normal sweep
    sweep(0, 4'b1000, 4'b1000);
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    sweep(0, 4'b1000, 4'b1000);
    tick(20);
    // SETTLE_CYCLES=1, XOR gate, start held 12 cycles
    lut[1]   = 4'b0110;
    expd[1]  = 4'b0110;
    start[1] = 1'b1;
    tick(12);
    start[1] = 1'b0;
    tick(6);

    // Randomized sweeps: random gates/expectations, long starts, aborts, churn on i_expected
    for (int it = 0; it < 60; it++) begin
      int         i;
      int         s;
      int         plen;
      int         ab_at;
      logic [3:0] l;
      i    = $urandom_range(0, 1);
      s    = settle(i);
      l    = 4'($urandom);
      plen = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0)      ab_at = 0;
      else if ($urandom_range(0, 4) == 0) ab_at = $urandom_range(1, 4 * s);
      else                                ab_at = -1;
      lut[i]  = l;
      expd[i] = ($urandom_range(0, 1) == 1) ? l : 4'($urandom);
      for (int j = 0; j < 4 * s + 7; j++) begin
        start[i] = (j < plen);
        abort[i] = (j == ab_at);
        if (j > 0 && $urandom_range(0, 2) == 0) expd[i] = 4'($urandom);
        tick(1);
      end
      start[i] = 1'b0;
      abort[i] = 1'b0;
      tick($urandom_range(0, 2));
    end

    tick(4);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
